// File: rtl/vp_arbiter.sv
// vp_arbiter: shares one vector processor between N_REQ requesters.
// Round-robin selection in IDLE, single outstanding operation, watchdog
// bounded wait on vp_done, one-cycle response strobe to the granted requester.
module vp_arbiter #(
  parameter int N_REQ   = 2,
  parameter int IDW     = 1,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [N_REQ*4-1:0]   req_operation,
  input  logic [N_REQ*64-1:0]  req_vec_a,
  input  logic [N_REQ*64-1:0]  req_vec_b,
  input  logic [N_REQ*16-1:0]  req_scalar,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [63:0]          rsp_result,
  output logic                 rsp_timeout,
  output logic [IDW-1:0]       grant_id,
  output logic                 vp_start,
  output logic [3:0]           vp_operation,
  output logic [63:0]          vp_vec_a,
  output logic [63:0]          vp_vec_b,
  output logic [15:0]          vp_scalar,
  input  logic                 vp_busy,
  input  logic                 vp_done,
  input  logic [63:0]          vp_result,
  input  logic                 vp_result_valid
);

  // Width needed to index a requester; IDW may be wider than this.
  localparam int IW = $clog2(N_REQ);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [IDW-1:0]   gid_q, gid_d;
  logic [7:0]       timer_q, timer_d;
  logic [3:0]       op_q, op_d;
  logic [63:0]      vec_a_q, vec_a_d;
  logic [63:0]      vec_b_q, vec_b_d;
  logic [15:0]      scalar_q, scalar_d;
  logic [63:0]      res_q, res_d;
  logic             to_q, to_d;
  logic [N_REQ-1:0] rsp_q, rsp_d;

  logic             win_found_s;
  logic [IW-1:0]    win_idx_s;
  logic [3:0]       sel_op_s;
  logic [63:0]      sel_a_s;
  logic [63:0]      sel_b_s;
  logic [15:0]      sel_scalar_s;
  logic [N_REQ-1:0] gid_onehot_s;
  logic             expire_s;

  // Completion is taken from vp_done only; result_valid is observed but unused.
  logic unused_ok;
  assign unused_ok = vp_result_valid;

  // Round-robin search: first valid requester after last_q, wrapping.
  always_comb begin
    int cand;
    cand        = 0;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = int'(last_q) + k;
      cand = (cand >= N_REQ) ? (cand - N_REQ) : cand;
      if (!win_found_s && req_valid[cand[IW-1:0]]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand[IW-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Operand mux for the current round-robin winner.
  always_comb begin
    sel_op_s     = 4'h0;
    sel_a_s      = 64'h0;
    sel_b_s      = 64'h0;
    sel_scalar_s = 16'h0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx_s == IW'(i)) begin
        sel_op_s     = req_operation[4*i +: 4];
        sel_a_s      = req_vec_a[64*i +: 64];
        sel_b_s      = req_vec_b[64*i +: 64];
        sel_scalar_s = req_scalar[16*i +: 16];
      end else begin
        sel_op_s     = sel_op_s;
      end
    end
  end

  // One-hot decode of the granted requester for the response strobe.
  always_comb begin
    gid_onehot_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      gid_onehot_s[i] = (gid_q == IDW'(i));
    end
  end

  // The vp_start cycle counts as the first cycle of the watchdog window, so
  // an aborted op responds exactly TIMEOUT cycles after vp_start.
  assign expire_s = ({1'b0, timer_q} + 9'd2) >= 9'(TIMEOUT);

  // Ready is offered only in IDLE and only to the winner, in the same cycle.
  always_comb begin
    req_ready = '0;
    if (!rst && (state_q == S_IDLE) && win_found_s) begin
      req_ready[win_idx_s] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Start pulse: first ISSUE cycle in which the VPU is free.
  assign vp_start = (state_q == S_ISSUE) && !vp_busy;

  // Next-state and datapath update for the IDLE/ISSUE/WAIT/RESP sequence.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gid_d    = gid_q;
    timer_d  = timer_q;
    op_d     = op_q;
    vec_a_d  = vec_a_q;
    vec_b_d  = vec_b_q;
    scalar_d = scalar_q;
    res_d    = res_q;
    to_d     = to_q;
    rsp_d    = '0;
    case (state_q)
      S_IDLE: begin
        if (win_found_s) begin
          op_d     = sel_op_s;
          vec_a_d  = sel_a_s;
          vec_b_d  = sel_b_s;
          scalar_d = sel_scalar_s;
          gid_d    = IDW'(win_idx_s);
          state_d  = S_ISSUE;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (!vp_busy) begin
          timer_d = 8'd0;
          state_d = S_WAIT;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT: begin
        timer_d = timer_q + 8'd1;
        if (vp_done) begin
          res_d   = vp_result;
          to_d    = 1'b0;
          rsp_d   = gid_onehot_s;
          state_d = S_RESP;
        end else if (expire_s) begin
          res_d   = 64'h0;
          to_d    = 1'b1;
          rsp_d   = gid_onehot_s;
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        last_d  = gid_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      last_q   <= IDW'(N_REQ - 1);
      gid_q    <= '0;
      timer_q  <= 8'd0;
      op_q     <= 4'h0;
      vec_a_q  <= 64'h0;
      vec_b_q  <= 64'h0;
      scalar_q <= 16'h0;
      res_q    <= 64'h0;
      to_q     <= 1'b0;
      rsp_q    <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gid_q    <= gid_d;
      timer_q  <= timer_d;
      op_q     <= op_d;
      vec_a_q  <= vec_a_d;
      vec_b_q  <= vec_b_d;
      scalar_q <= scalar_d;
      res_q    <= res_d;
      to_q     <= to_d;
      rsp_q    <= rsp_d;
    end
  end

  assign rsp_valid    = rsp_q;
  assign rsp_result   = res_q;
  assign rsp_timeout  = to_q;
  assign grant_id     = gid_q;
  assign vp_operation = op_q;
  assign vp_vec_a     = vec_a_q;
  assign vp_vec_b     = vec_b_q;
  assign vp_scalar    = scalar_q;

endmodule

// File: tb/tb_vp_arbiter.sv
// Testbench for vp_arbiter: directed scenarios plus randomized traffic,
// responses checked by a scoreboard fed from the stimulus side.
module tb_vp_arbiter;
  localparam int N_REQ   = 2;
  localparam int IDW     = 1;
  localparam int TIMEOUT = 255;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [N_REQ-1:0]    req_valid, req_ready, rsp_valid;
  logic [N_REQ*4-1:0]  req_operation;
  logic [N_REQ*64-1:0] req_vec_a, req_vec_b;
  logic [N_REQ*16-1:0] req_scalar;
  logic [63:0]         rsp_result;
  logic                rsp_timeout;
  logic [IDW-1:0]      grant_id;
  logic                vp_start;
  logic [3:0]          vp_operation;
  logic [63:0]         vp_vec_a, vp_vec_b;
  logic [15:0]         vp_scalar;
  logic                vp_busy, vp_done, vp_result_valid;
  logic [63:0]         vp_result;

  logic [3:0]  op_arr [N_REQ];
  logic [63:0] a_arr  [N_REQ];
  logic [63:0] b_arr  [N_REQ];
  logic [15:0] s_arr  [N_REQ];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_g;
  int vpu_lat;
  logic [63:0] vpu_res;

  typedef struct {
    int          w;
    logic [63:0] res;
    logic        to;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  vp_arbiter #(.N_REQ(N_REQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_operation(req_operation), .req_vec_a(req_vec_a),
    .req_vec_b(req_vec_b), .req_scalar(req_scalar),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_timeout(rsp_timeout),
    .grant_id(grant_id), .vp_start(vp_start), .vp_operation(vp_operation),
    .vp_vec_a(vp_vec_a), .vp_vec_b(vp_vec_b), .vp_scalar(vp_scalar),
    .vp_busy(vp_busy), .vp_done(vp_done), .vp_result(vp_result),
    .vp_result_valid(vp_result_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign vp_result_valid = vp_done;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_operation[4*i +: 4] = op_arr[i];
      req_vec_a[64*i +: 64]   = a_arr[i];
      req_vec_b[64*i +: 64]   = b_arr[i];
      req_scalar[16*i +: 16]  = s_arr[i];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [N_REQ-1:0] onehot(input int w);
    onehot = N_REQ'(1) << w;
  endfunction

  // Reference arbitration: first asserted request after the last grant, wrapping.
  function automatic int rr_pick(input int last, input logic [N_REQ-1:0] m);
    logic [N_REQ-1:0] t;
    int idx;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (last + k) % N_REQ;
      t = m >> idx;
      if (t[0]) return idx;
    end
    return 0;
  endfunction

  task automatic randomize_ops();
    for (int i = 0; i < N_REQ; i++) begin
      op_arr[i] = 4'($urandom);
      a_arr[i]  = {$urandom, $urandom};
      b_arr[i]  = {$urandom, $urandom};
      s_arr[i]  = 16'($urandom);
    end
  endtask

  // Behavioural VPU: done pulse 'vpu_lat' cycles after the start cycle (0 = never).
  initial begin
    vp_done   = 1'b0;
    vp_result = 64'h0;
    forever begin
      @(negedge clk);
      if (vp_start && !rst && vpu_lat > 0) begin
        repeat (vpu_lat) @(posedge clk);
        #1;
        vp_done   = 1'b1;
        vp_result = vpu_res;
        @(posedge clk);
        #1;
        vp_done   = 1'b0;
        vp_result = {$urandom, $urandom};
      end
    end
  end

  // Response monitor: every strobe must match the oldest expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid != '0) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_valid", 64'(rsp_valid), 64'(onehot(e.w)));
          chk("rsp_result", rsp_result, e.res);
          chk("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
          chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  // Starts at a rising edge; presents mask m, checks acceptance and the start pulse.
  task automatic launch(input logic [N_REQ-1:0] m, input int busy, input int lat,
                        input logic [63:0] res, input bit push);
    int w, s_cyc, bad;
    logic [3:0] eop;
    logic [63:0] ea, eb;
    logic [15:0] es;
    exp_t e;
    #1;
    req_valid = m;
    vp_busy   = (busy > 0);
    vpu_lat   = lat;
    vpu_res   = res;
    w = rr_pick(last_g, m);
    last_g = w;
    eop = op_arr[w]; ea = a_arr[w]; eb = b_arr[w]; es = s_arr[w];
    @(negedge clk);
    chk("req_ready_accept", 64'(req_ready), 64'(onehot(w)));
    @(posedge clk);
    #1;
    req_valid = req_valid & ~onehot(w);
    randomize_ops();
    bad = 0;
    for (int k = 1; k <= busy; k++) begin
      @(negedge clk);
      if (vp_start !== 1'b0 || req_ready !== '0) bad++;
      @(posedge clk);
      #1;
    end
    vp_busy = 1'b0;
    if (busy > 0) chk("busy_hold_no_start", 64'(bad), 64'd0);
    @(negedge clk);
    s_cyc = cyc;
    chk("vp_start_pulse", 64'(vp_start), 64'd1);
    chk("grant_id", 64'(grant_id), 64'(w));
    chk("vp_operation", 64'(vp_operation), 64'(eop));
    chk("vp_vec_a", vp_vec_a, ea);
    chk("vp_vec_b", vp_vec_b, eb);
    chk("vp_scalar", 64'(vp_scalar), 64'(es));
    chk("ready_outside_idle", 64'(req_ready), 64'd0);
    if (push) begin
      e.w = w;
      if (lat > 0 && lat < TIMEOUT) begin
        e.res = res; e.to = 1'b0; e.cyc = s_cyc + lat + 1;
      end else begin
        e.res = 64'h0; e.to = 1'b1; e.cyc = s_cyc + TIMEOUT;
      end
      sb.push_back(e);
    end
    @(negedge clk);
    chk("vp_start_single", 64'(vp_start), 64'd0);
  endtask

  // Returns at the rising edge after the last expected response was consumed.
  task automatic wait_rsp(input int bound);
    int n;
    n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("rsp_wait_bound", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    int bad;
    logic [N_REQ-1:0] m;
    req_valid = '0;
    vp_busy   = 1'b0;
    vpu_lat   = 0;
    vpu_res   = 64'h0;
    last_g    = N_REQ - 1;
    randomize_ops();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_vp_start", 64'(vp_start), 64'd0);
    chk("reset_grant_id", 64'(grant_id), 64'd0);
    chk("reset_rsp_result", rsp_result, 64'd0);
    chk("reset_vp_vec_a", vp_vec_a, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_ready", 64'(req_ready), 64'd0);
    @(posedge clk);

    // Single operation from requester 0.
    op_arr[0] = 4'h2;
    a_arr[0]  = 64'h1;
    launch(2'b01, 0, 3, 64'hAB, 1'b1);
    wait_rsp(40);

    // Both requesters continuously valid: grants alternate.
    for (int i = 0; i < 4; i++) begin
      launch(2'b11, 0, $urandom_range(1, 6), {$urandom, $urandom}, 1'b1);
      wait_rsp(40);
    end
    req_valid = '0;

    // VPU busy for 5 cycles at acceptance.
    launch(2'b01, 5, 4, {$urandom, $urandom}, 1'b1);
    wait_rsp(40);

    // Watchdog abort, then a stale done one cycle after the response.
    launch(2'b01, 0, TIMEOUT + 1, {$urandom, $urandom}, 1'b1);
    wait_rsp(TIMEOUT + 40);
    repeat (4) @(posedge clk);

    // Requester 1 pulses valid while requester 0 is in WAIT.
    launch(2'b01, 0, 10, {$urandom, $urandom}, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    req_valid = 2'b10;
    @(negedge clk);
    chk("withdrawn_no_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_rsp(30);
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (vp_start !== 1'b0 || req_ready !== '0) bad++;
    end
    chk("withdrawn_no_start", 64'(bad), 64'd0);
    @(posedge clk);

    // Reset while waiting on the VPU.
    launch(2'b01, 0, 20, {$urandom, $urandom}, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midreset_vp_start", 64'(vp_start), 64'd0);
    chk("midreset_grant_id", 64'(grant_id), 64'd0);
    chk("midreset_rsp_result", rsp_result, 64'd0);
    chk("midreset_rsp_timeout", 64'(rsp_timeout), 64'd0);
    chk("midreset_vp_operation_a", vp_vec_a, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    last_g = N_REQ - 1;
    repeat (30) @(posedge clk);
    launch(2'b10, 0, 5, {$urandom, $urandom}, 1'b1);
    wait_rsp(40);

    // Randomized traffic.
    for (int i = 0; i < 20; i++) begin
      m = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
      launch(m, $urandom_range(0, 3),
             ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12),
             {$urandom, $urandom}, 1'b1);
      wait_rsp(TIMEOUT + 40);
      req_valid = '0;
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vp_arbiter.md
Name: vp_arbiter

Overview:
- Shares the single vector_processor between N_REQ shader-side requesters, e.g. the shader pipeline and the convolution post-processor.
- Accepts one operation at a time via a valid/ready handshake, using round-robin selection.
- Issues the operation to the VPU and waits for vp_done, bounded by a watchdog timeout.
- Returns the result to the granted requester with a one-cycle response strobe.

Parameters:
N_REQ, 2, number of requesters (2..8)
IDW, 1, grant id width; must satisfy 2**IDW >= N_REQ
TIMEOUT, 255, max cycles in WAIT before abort (1..255)

Ports:
clk  in  1  system clock (25 MHz pixel clock)
rst  in  1  asynchronous, active-high reset
req_valid  in  N_REQ  request pending, one bit per requester
req_ready  out  N_REQ  request accepted this cycle (one-hot or zero)
req_operation  in  N_REQ*4  per-requester opcode, requester i at [4i+3:4i]
req_vec_a  in  N_REQ*64  operand A, slice [64i+63:64i]
req_vec_b  in  N_REQ*64  operand B
req_scalar  in  N_REQ*16  scalar operand
rsp_valid  out  N_REQ  one-cycle result strobe to the granted requester
rsp_result  out  64  result, shared bus; valid while rsp_valid!=0
rsp_timeout  out  1  high with rsp_valid when the op was aborted
grant_id  out  IDW  index of current/last granted requester
vp_start  out  1  VPU start pulse
vp_operation  out  4  latched opcode
vp_vec_a  out  64  latched operand A
vp_vec_b  out  64  latched operand B
vp_scalar  out  16  latched scalar
vp_busy  in  1  VPU busy
vp_done  in  1  VPU completion pulse
vp_result  in  64  VPU result
vp_result_valid  in  1  monitored only; completion is vp_done

Behaviour:
- Reset (async, rst=1) puts the block in IDLE with:
  - all outputs 0, operand latches 0, timer 0;
  - last_grant = N_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - The winner is the first requester with req_valid=1, searching (last_grant+1) mod N_REQ upward with wrap.
  - req_ready[winner] is driven combinationally high in the same cycle.
  - Transfer occurs on valid&ready. Operands and opcode are latched, grant_id<=winner, next state ISSUE.
  - No valid: stay in IDLE, req_ready=0.
- req_ready is nonzero only in IDLE. A requester must hold valid and operands stable until ready. Deasserting valid before ready is legal: no transfer occurs.
- ISSUE:
  - If vp_busy=0: vp_start=1 for exactly one cycle, timer<=0, next state WAIT.
  - If vp_busy=1: hold in ISSUE with vp_start=0 until vp_busy=0.
- vp_operation/vec_a/vec_b/scalar hold the latched values from acceptance until the next acceptance.
- WAIT:
  - Timer increments each cycle.
  - vp_done=1: rsp_result<=vp_result, rsp_timeout<=0, next state RESP.
  - Timer reaches TIMEOUT without vp_done: rsp_result<=0, rsp_timeout<=1, next state RESP.
  - If vp_done and timeout coincide, vp_done wins.
- RESP:
  - rsp_valid[grant_id]=1 for one cycle; last_grant<=grant_id; next state IDLE.
  - rsp_result and rsp_timeout hold until the next RESP.
- vp_done outside WAIT is ignored, including a stale completion after a timeout.
- Latency with acceptance in cycle T:
  - vp_start at T+1;
  - if vp_done arrives at cycle D, rsp_valid at D+1.
- Minimum spacing between acceptances is 4 cycles plus VPU time: IDLE→ISSUE→WAIT→RESP→IDLE.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,N_REQ-1,0,...; no requester waits more than N_REQ-1 operations.
- Reset mid-operation: immediate return to IDLE. vp_start drops, no rsp_valid is issued, and the in-flight VPU result is discarded.
- Timer is 8 bits. TIMEOUT=0 is illegal.

Test Plan:
- Single op: req_valid[0]=1, op=4'h2, vec_a=64'h1, VPU model done 3 cycles after start with result 64'hAB → req_ready[0] at T, vp_start at T+1, rsp_valid=2'b01 at T+5, rsp_result=64'hAB, rsp_timeout=0.
- Round-robin: both valid continuously for 4 ops → grant_id sequence 0,1,0,1; each rsp_valid goes only to its own requester; first grant after reset is 0.
- Busy hold: vp_busy=1 for 5 cycles at acceptance → vp_start is asserted only in the first cycle vp_busy=0, exactly one pulse.
- Timeout: VPU never asserts done, TIMEOUT=255 → rsp_valid with rsp_timeout=1, rsp_result=0, 255 cycles after vp_start. A late vp_done one cycle after RESP is ignored and produces no extra rsp_valid.
- Reset mid-WAIT: rst pulsed while waiting → all outputs 0 immediately. A subsequent done produces no response. The next request from requester 1 alone is granted normally.
- Valid withdrawn: req_valid[1] pulsed for 1 cycle while the arbiter is in WAIT for requester 0 → no acceptance for requester 1 and no vp_start for it.
